// File: rtl/pic_ack_sequencer.sv
// ---------------------------------------------------------------------------
// pic_ack_sequencer: 8259 priority resolver, INTA handshake and EOI sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pic_ack_sequencer #(
  parameter int         NUM_IRQ      = 8,
  parameter logic [2:0] RESET_LOWEST = 3'd7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               inta_n,
  input  logic [4:0]         vector_base,
  input  logic               aeoi_mode,
  input  logic               rotate_on_aeoi,
  input  logic               ocw2_wr,
  input  logic [2:0]         ocw2_cmd,
  input  logic [2:0]         ocw2_level,
  output logic               int_out,
  output logic [NUM_IRQ-1:0] irr_clear,
  output logic [NUM_IRQ-1:0] isr,
  output logic [2:0]         lowest_priority,
  output logic [7:0]         data_out,
  output logic               data_oe
);

  typedef enum logic [2:0] {IDLE, REQ, ACK1, GAP, ACK2} state_t;

  state_t             state, state_nx;
  logic               inta_n_d;
  logic [2:0]         idx, idx_nx;
  logic               spurious, spurious_nx;
  logic               int_nx, data_oe_nx;
  logic [7:0]         data_out_nx;
  logic [NUM_IRQ-1:0] irr_clear_nx, isr_nx;
  logic [2:0]         lowest_nx;

  logic [NUM_IRQ-1:0] cand;
  logic [3:0]         win, isr_top;
  logic               win_valid, isr_valid, qualify;
  logic [2:0]         win_rank, win_lvl, isr_rank, isr_lvl;
  logic               inta_fall, inta_rise;

  logic [NUM_IRQ-1:0] isr_set, aeoi_clr, ocw_clr;
  logic               aeoi_rot, ocw_rot;
  logic [2:0]         ocw_lvl;

  // Returns {found, rank} of the best-ranked set bit; rank 0 sits just above lp.
  function automatic logic [3:0] find_top(input logic [NUM_IRQ-1:0] vec,
                                          input logic [2:0] lp);
    logic [2:0] lvl;
    find_top = 4'd0;
    for (int r = NUM_IRQ - 1; r >= 0; r--) begin
      lvl = lp + 3'(r) + 3'd1;
      if (vec[lvl]) find_top = {1'b1, 3'(r)};
    end
  endfunction

  assign cand      = irr & ~imr;
  assign win       = find_top(cand, lowest_priority);
  assign win_valid = win[3];
  assign win_rank  = win[2:0];
  assign win_lvl   = win_rank + lowest_priority + 3'd1;
  assign isr_top   = find_top(isr, lowest_priority);
  assign isr_valid = isr_top[3];
  assign isr_rank  = isr_top[2:0];
  assign isr_lvl   = isr_rank + lowest_priority + 3'd1;
  assign qualify   = win_valid && (!isr_valid || (win_rank < isr_rank));

  assign inta_fall = inta_n_d & ~inta_n;
  assign inta_rise = ~inta_n_d & inta_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      inta_n_d        <= 1'b1;
      int_out         <= 1'b0;
      irr_clear       <= '0;
      isr             <= '0;
      lowest_priority <= RESET_LOWEST;
      idx             <= 3'd0;
      spurious        <= 1'b0;
      data_out        <= 8'd0;
      data_oe         <= 1'b0;
    end else begin
      state           <= state_nx;
      inta_n_d        <= inta_n;
      int_out         <= int_nx;
      irr_clear       <= irr_clear_nx;
      isr             <= isr_nx;
      lowest_priority <= lowest_nx;
      idx             <= idx_nx;
      spurious        <= spurious_nx;
      data_out        <= data_out_nx;
      data_oe         <= data_oe_nx;
    end
  end

  // Acknowledge sequence
  always_comb begin
    state_nx     = state;
    int_nx       = int_out;
    irr_clear_nx = '0;
    idx_nx       = idx;
    spurious_nx  = spurious;
    data_out_nx  = data_out;
    data_oe_nx   = data_oe;
    isr_set      = '0;
    aeoi_clr     = '0;
    aeoi_rot     = 1'b0;
    case (state)
      IDLE: begin
        if (qualify) begin
          int_nx   = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (inta_fall) begin
          if (win_valid) begin
            idx_nx                = win_lvl;
            isr_set[win_lvl]      = 1'b1;
            irr_clear_nx[win_lvl] = 1'b1;
            spurious_nx           = 1'b0;
          end else begin
            // Request withdrawn before acknowledge: hand out the IR7 vector.
            idx_nx      = 3'd7;
            spurious_nx = 1'b1;
          end
          int_nx   = 1'b0;
          state_nx = ACK1;
        end
      end
      ACK1: begin
        if (inta_rise) state_nx = GAP;
      end
      GAP: begin
        if (inta_fall) begin
          data_out_nx = {vector_base, idx};
          data_oe_nx  = 1'b1;
          state_nx    = ACK2;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          data_oe_nx = 1'b0;
          if (aeoi_mode && !spurious) begin
            aeoi_clr[idx] = 1'b1;
            aeoi_rot      = rotate_on_aeoi;
          end
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // OCW2 command decode
  always_comb begin
    ocw_clr = '0;
    ocw_rot = 1'b0;
    ocw_lvl = ocw2_level;
    if (ocw2_wr) begin
      case (ocw2_cmd)
        3'b001: if (isr_valid) ocw_clr[isr_lvl] = 1'b1;
        3'b011: ocw_clr[ocw2_level] = 1'b1;
        3'b101: begin
          if (isr_valid) begin
            ocw_clr[isr_lvl] = 1'b1;
            ocw_rot          = 1'b1;
            ocw_lvl          = isr_lvl;
          end
        end
        3'b111: begin
          ocw_clr[ocw2_level] = 1'b1;
          ocw_rot             = 1'b1;
        end
        3'b110: ocw_rot = 1'b1;
        default: ;
      endcase
    end
  end

  // A set from the acknowledge wins over any clear of the same bit.
  always_comb begin
    isr_nx    = (isr & ~ocw_clr & ~aeoi_clr) | isr_set;
    lowest_nx = lowest_priority;
    if (ocw_rot)       lowest_nx = ocw_lvl;
    else if (aeoi_rot) lowest_nx = idx;
  end

endmodule

`default_nettype wire

// File: tb/tb_pic_ack_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pic_ack_sequencer: directed, self-checking bench for pic_ack_sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pic_ack_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] irr, imr;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       aeoi_mode, rotate_on_aeoi;
  logic       ocw2_wr;
  logic [2:0] ocw2_cmd, ocw2_level;
  logic       int_out;
  logic [7:0] irr_clear, isr;
  logic [2:0] lowest_priority;
  logic [7:0] data_out;
  logic       data_oe;

  int checks = 0;
  int errors = 0;

  pic_ack_sequencer #(.NUM_IRQ(8), .RESET_LOWEST(3'd7)) dut (
    .clk(clk), .reset_n(reset_n), .irr(irr), .imr(imr), .inta_n(inta_n),
    .vector_base(vector_base), .aeoi_mode(aeoi_mode),
    .rotate_on_aeoi(rotate_on_aeoi), .ocw2_wr(ocw2_wr), .ocw2_cmd(ocw2_cmd),
    .ocw2_level(ocw2_level), .int_out(int_out), .irr_clear(irr_clear),
    .isr(isr), .lowest_priority(lowest_priority), .data_out(data_out),
    .data_oe(data_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] irr;
    logic [7:0] imr;
    logic [2:0] lp;
    logic       exp_int;
    logic [2:0] exp_lvl;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; irr = 8'h00; imr = 8'h00; inta_n = 1'b1;
    ocw2_wr = 1'b0; ocw2_cmd = 3'b000; ocw2_level = 3'd0;
    aeoi_mode = 1'b0; rotate_on_aeoi = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic ocw(input logic [2:0] cmd, input logic [2:0] lvl);
    ocw2_wr = 1'b1; ocw2_cmd = cmd; ocw2_level = lvl;
    tick();
    ocw2_wr = 1'b0;
  endtask

  // Full two-pulse acknowledge; optional OCW2 set-priority on the final rise.
  task automatic ack(input string tag, input logic [7:0] exp_isr, input logic [7:0] exp_clr,
                     input logic [7:0] exp_vec, input logic [7:0] irr_after,
                     input logic end_ocw, input logic [2:0] end_lvl);
    inta_n = 1'b0;
    tick();
    chk({tag, " isr after 1st inta"}, isr, exp_isr);
    chk({tag, " irr_clear pulse"}, irr_clear, exp_clr);
    chk({tag, " int_out dropped"}, {7'd0, int_out}, 8'h00);
    irr = irr_after;
    tick();
    chk({tag, " irr_clear one cycle"}, irr_clear, 8'h00);
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    tick();
    chk({tag, " data_oe on 2nd inta"}, {7'd0, data_oe}, 8'h01);
    chk({tag, " vector"}, data_out, exp_vec);
    inta_n = 1'b1;
    if (end_ocw) begin
      ocw2_wr = 1'b1; ocw2_cmd = 3'b110; ocw2_level = end_lvl;
    end
    tick();
    ocw2_wr = 1'b0;
    chk({tag, " data_oe released"}, {7'd0, data_oe}, 8'h00);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{irr: 8'h24, imr: 8'h00, lp: 3'd7, exp_int: 1'b1, exp_lvl: 3'd2};
    tbl[1] = '{irr: 8'h24, imr: 8'h04, lp: 3'd7, exp_int: 1'b1, exp_lvl: 3'd5};
    tbl[2] = '{irr: 8'h81, imr: 8'h00, lp: 3'd0, exp_int: 1'b1, exp_lvl: 3'd7};
    tbl[3] = '{irr: 8'h11, imr: 8'h00, lp: 3'd3, exp_int: 1'b1, exp_lvl: 3'd4};
    tbl[4] = '{irr: 8'hFF, imr: 8'hFF, lp: 3'd7, exp_int: 1'b0, exp_lvl: 3'd0};
    tbl[5] = '{irr: 8'h40, imr: 8'h00, lp: 3'd6, exp_int: 1'b1, exp_lvl: 3'd6};

    vector_base = 5'b10101;
    do_reset();
    chk("reset isr", isr, 8'h00);
    chk("reset lowest", {5'd0, lowest_priority}, 8'h07);
    chk("reset int_out", {7'd0, int_out}, 8'h00);
    chk("reset data_oe/data_out", {data_out[6:0], data_oe}, 8'h00);

    // Priority resolution table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      ocw(3'b110, tbl[i].lp);
      chk($sformatf("tbl%0d lowest", i), {5'd0, lowest_priority}, {5'd0, tbl[i].lp});
      irr = tbl[i].irr; imr = tbl[i].imr;
      tick();
      chk($sformatf("tbl%0d int_out", i), {7'd0, int_out}, {7'd0, tbl[i].exp_int});
      if (tbl[i].exp_int)
        ack($sformatf("tbl%0d", i), 8'h01 << tbl[i].exp_lvl, 8'h01 << tbl[i].exp_lvl,
            {5'b10101, tbl[i].exp_lvl}, 8'h00, 1'b0, 3'd0);
      else begin
        tick();
        chk($sformatf("tbl%0d int stays low", i), {7'd0, int_out}, 8'h00);
      end
    end

    // Basic cycle followed by a nested higher-priority request
    do_reset();
    vector_base = 5'b01000;
    irr = 8'h24;
    chk("basic int before", {7'd0, int_out}, 8'h00);
    tick();
    chk("basic int_out", {7'd0, int_out}, 8'h01);
    ack("basic", 8'h04, 8'h04, 8'h42, 8'h20, 1'b0, 3'd0);
    chk("basic data_out holds", data_out, 8'h42);
    tick(); tick();
    chk("nest lower blocked", {7'd0, int_out}, 8'h00);
    irr = 8'h21;
    tick();
    chk("nest higher int", {7'd0, int_out}, 8'h01);
    ack("nest", 8'h05, 8'h01, 8'h40, 8'h20, 1'b0, 3'd0);
    ocw(3'b001, 3'd0);
    chk("nest ns-eoi", isr, 8'h04);
    irr = 8'h00;
    ocw(3'b001, 3'd0);
    chk("basic ns-eoi", isr, 8'h00);

    // AEOI with rotation; second cycle also exercises OCW2-over-AEOI rotation
    do_reset();
    vector_base = 5'b01000;
    aeoi_mode = 1'b1; rotate_on_aeoi = 1'b1;
    irr = 8'h08;
    tick();
    ack("aeoi1", 8'h08, 8'h08, 8'h43, 8'h00, 1'b0, 3'd0);
    chk("aeoi1 isr cleared", isr, 8'h00);
    chk("aeoi1 rotated", {5'd0, lowest_priority}, 8'h03);
    irr = 8'h11;
    tick();
    ack("aeoi2", 8'h10, 8'h10, 8'h44, 8'h00, 1'b1, 3'd1);
    chk("aeoi2 isr cleared", isr, 8'h00);
    chk("aeoi2 ocw rotation wins", {5'd0, lowest_priority}, 8'h01);

    // Spurious: request withdrawn before the first INTA
    do_reset();
    vector_base = 5'b01000;
    irr = 8'h02;
    tick();
    chk("spur int_out", {7'd0, int_out}, 8'h01);
    irr = 8'h00;
    ack("spur", 8'h00, 8'h00, 8'h47, 8'h00, 1'b0, 3'd0);
    chk("spur isr", isr, 8'h00);

    // OCW2 commands
    do_reset();
    irr = 8'h04;
    tick();
    ack("cmd a", 8'h04, 8'h04, 8'h42, 8'h00, 1'b0, 3'd0);
    irr = 8'h02;
    tick();
    chk("cmd nested int", {7'd0, int_out}, 8'h01);
    ack("cmd b", 8'h06, 8'h02, 8'h41, 8'h00, 1'b0, 3'd0);
    ocw(3'b111, 3'd2);
    chk("rot spec eoi isr", isr, 8'h02);
    chk("rot spec eoi lowest", {5'd0, lowest_priority}, 8'h02);
    ocw(3'b110, 3'd5);
    chk("set prio lowest", {5'd0, lowest_priority}, 8'h05);
    ocw(3'b011, 3'd1);
    chk("spec eoi isr", isr, 8'h00);
    ocw(3'b001, 3'd0);
    chk("ns-eoi empty isr", isr, 8'h00);
    chk("ns-eoi empty lowest", {5'd0, lowest_priority}, 8'h05);
    ocw(3'b101, 3'd0);
    chk("rot ns-eoi empty lowest", {5'd0, lowest_priority}, 8'h05);

    // Asynchronous reset in the middle of ACK2
    do_reset();
    ocw(3'b110, 3'd2);
    irr = 8'h01;
    tick();
    inta_n = 1'b0; tick();
    irr = 8'h00; tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    chk("pre-reset data_oe", {7'd0, data_oe}, 8'h01);
    chk("pre-reset isr", isr, 8'h01);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset isr", isr, 8'h00);
    chk("async reset lowest", {5'd0, lowest_priority}, 8'h07);
    chk("async reset data_oe", {7'd0, data_oe}, 8'h00);
    chk("async reset int_out", {7'd0, int_out}, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    chk("post-reset inta ignored oe", {7'd0, data_oe}, 8'h00);
    chk("post-reset inta ignored isr", isr, 8'h00);
    inta_n = 1'b1; tick();
    chk("post-reset int_out", {7'd0, int_out}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
